mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/cpu_defs.sv | 43 ++++
 rtl/load_align.sv | 24 ++
 rtl/mem_access.sv | 153 +++++++++++++++
 tb/tb_mem_access.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: memory op encoding, memory-stage states and register write requests.
package cpu_defs;

    typedef enum logic [2:0] {LB, LBU, LH, LHU, LW, SB, SH, SW} MemOp_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} MemState_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } RegWriteReq_t;

    function automatic logic is_load(input MemOp_t op);
        return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
    endfunction

    function automatic logic is_misaligned(input MemOp_t op, input logic [1:0] a);
        case (op)
            LH, LHU, SH: return a[0];
            LW, SW:      return a != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    // Byte enables follow the access size; loads use the same lanes as stores.
    function automatic logic [3:0] access_be(input MemOp_t op, input logic [1:0] a);
        case (op)
            LB, LBU, SB: return 4'b0001 << a;
            LH, LHU, SH: return a[1] ? 4'b1100 : 4'b0011;
            default:     return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input MemOp_t op, input logic [31:0] wd);
        case (op)
            SB:      return {4{wd[7:0]}};
            SH:      return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half lane out of a little-endian read word and extends it.
module load_align
    import cpu_defs::*;
(
    input  MemOp_t      op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] wdata
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {addr, 3'b000};
        case (op)
            LB:      wdata = {{24{shifted[7]}}, shifted[7:0]};
            LBU:     wdata = {24'h0, shifted[7:0]};
            LH:      wdata = {{16{shifted[15]}}, shifted[15:0]};
            LHU:     wdata = {16'h0, shifted[15:0]};
            default: wdata = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: issues loads/stores on the data bus, stalls the pipe while waiting,
// and aligns load data into the register write request for MEM/WB.
module mem_access
    import cpu_defs::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_req,
    input  MemOp_t       mem_op,
    input  logic [31:0]  mem_addr,
    input  logic [31:0]  mem_wdata,
    input  RegWriteReq_t ex_reg_wr,
    input  logic         flush,
    output logic         dbus_req,
    output logic         dbus_we,
    output logic [3:0]   dbus_be,
    output logic [31:0]  dbus_addr,
    output logic [31:0]  dbus_wdata,
    input  logic         dbus_ready,
    input  logic [31:0]  dbus_rdata,
    output RegWriteReq_t mem_reg_wr,
    output logic         stall_req,
    output logic         addr_err_load,
    output logic         addr_err_store,
    output logic [31:0]  badvaddr
);

    MemState_t    state_q, next_state;
    logic         drop_q;
    MemOp_t       op_q;
    logic [31:0]  addr_q, wdata_q, rdata_q;
    RegWriteReq_t reg_wr_q;

    logic         misaligned, issue;
    MemOp_t       align_op;
    logic [1:0]   align_addr;
    logic [31:0]  align_rdata, aligned;

    assign misaligned = is_misaligned(mem_op, mem_addr[1:0]);
    assign issue      = (state_q == IDLE) && mem_req && !flush && !misaligned;

    // A zero-wait access aligns the live bus word; otherwise the captured word is used.
    assign align_op    = (state_q == IDLE) ? mem_op         : op_q;
    assign align_addr  = (state_q == IDLE) ? mem_addr[1:0]  : addr_q[1:0];
    assign align_rdata = (state_q == IDLE) ? dbus_rdata     : rdata_q;

    load_align u_load_align (
        .op    (align_op),
        .addr  (align_addr),
        .rdata (align_rdata),
        .wdata (aligned)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // Captured request, read word and the discard flag for a flushed in-flight access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_q   <= 1'b0;
            op_q     <= LB;
            addr_q   <= '0;
            wdata_q  <= '0;
            reg_wr_q <= '0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    drop_q <= 1'b0;
                    if (issue && !dbus_ready) begin
                        op_q     <= mem_op;
                        addr_q   <= mem_addr;
                        wdata_q  <= mem_wdata;
                        reg_wr_q <= ex_reg_wr;
                    end
                end
                BUSY: begin
                    if (flush) drop_q <= 1'b1;
                    if (dbus_ready) rdata_q <= dbus_rdata;
                end
                default: drop_q <= 1'b0;
            endcase
        end
    end

    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE:    if (issue && !dbus_ready) next_state = BUSY;
            BUSY:    if (dbus_ready) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        dbus_req       = 1'b0;
        dbus_we        = 1'b0;
        dbus_be        = 4'b0000;
        dbus_addr      = '0;
        dbus_wdata     = '0;
        mem_reg_wr     = '0;
        stall_req      = 1'b0;
        addr_err_load  = 1'b0;
        addr_err_store = 1'b0;
        badvaddr       = '0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    mem_reg_wr = ex_reg_wr;
                    if (flush) begin
                        mem_reg_wr.we = 1'b0;
                    end else if (mem_req && misaligned) begin
                        addr_err_load  = is_load(mem_op);
                        addr_err_store = !is_load(mem_op);
                        badvaddr       = mem_addr;
                        mem_reg_wr.we  = 1'b0;
                    end else if (mem_req) begin
                        dbus_req   = 1'b1;
                        dbus_we    = !is_load(mem_op);
                        dbus_be    = access_be(mem_op, mem_addr[1:0]);
                        dbus_addr  = {mem_addr[31:2], 2'b00};
                        dbus_wdata = store_data(mem_op, mem_wdata);
                        if (dbus_ready) begin
                            if (is_load(mem_op)) mem_reg_wr.wdata = aligned;
                        end else begin
                            stall_req     = 1'b1;
                            mem_reg_wr.we = 1'b0;
                        end
                    end
                end
                BUSY: begin
                    dbus_req   = 1'b1;
                    dbus_we    = !is_load(op_q);
                    dbus_be    = access_be(op_q, addr_q[1:0]);
                    dbus_addr  = {addr_q[31:2], 2'b00};
                    dbus_wdata = store_data(op_q, wdata_q);
                    stall_req  = 1'b1;
                end
                default: begin
                    mem_reg_wr = reg_wr_q;
                    if (is_load(op_q)) mem_reg_wr.wdata = aligned;
                    if (drop_q || flush) mem_reg_wr.we = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access against a transaction-level model of the MEM stage.
module tb_mem_access;
    import cpu_defs::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_req;
    MemOp_t       mem_op;
    logic [31:0]  mem_addr, mem_wdata;
    RegWriteReq_t ex_reg_wr;
    logic         flush;
    logic         dbus_req, dbus_we;
    logic [3:0]   dbus_be;
    logic [31:0]  dbus_addr, dbus_wdata;
    logic         dbus_ready;
    logic [31:0]  dbus_rdata;
    RegWriteReq_t mem_reg_wr;
    logic         stall_req, addr_err_load, addr_err_store;
    logic [31:0]  badvaddr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_op(mem_op),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .ex_reg_wr(ex_reg_wr), .flush(flush),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_be(dbus_be), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_ready(dbus_ready), .dbus_rdata(dbus_rdata),
        .mem_reg_wr(mem_reg_wr), .stall_req(stall_req), .addr_err_load(addr_err_load),
        .addr_err_store(addr_err_store), .badvaddr(badvaddr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input MemOp_t op, input logic [31:0] addr,
                                 input logic [31:0] wd, input RegWriteReq_t rw, input logic fl,
                                 input logic rdy, input logic [31:0] rd);
        mem_req    = req;
        mem_op     = op;
        mem_addr   = addr;
        mem_wdata  = wd;
        ex_reg_wr  = rw;
        flush      = fl;
        dbus_ready = rdy;
        dbus_rdata = rd;
    endtask

    function automatic bit modelIsLoad(input MemOp_t op);
        return op inside {LB, LBU, LH, LHU, LW};
    endfunction

    function automatic int unsigned modelSize(input MemOp_t op);
        if (op inside {LB, LBU, SB}) return 1;
        if (op inside {LH, LHU, SH}) return 2;
        return 4;
    endfunction

    function automatic bit modelMisaligned(input MemOp_t op, input logic [31:0] addr);
        return (addr % modelSize(op)) != 0;
    endfunction

    function automatic logic [31:0] modelLoad(input MemOp_t op, input logic [31:0] addr, input logic [31:0] rd);
        logic [31:0] v;
        int unsigned sh = (addr % 4) * 8;
        case (modelSize(op))
            1: begin
                v = (rd >> sh) & 32'hFF;
                if (op == LB && v >= 128) v = v + 32'hFFFF_FF00;
            end
            2: begin
                v = (rd >> sh) & 32'hFFFF;
                if (op == LH && v >= 32768) v = v + 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] modelBe(input MemOp_t op, input logic [31:0] addr);
        case (modelSize(op))
            1:       return 32'd1 << (addr % 4);
            2:       return ((addr % 4) == 0) ? 32'd3 : 32'd12;
            default: return 32'd15;
        endcase
    endfunction

    function automatic logic [31:0] modelStoreData(input MemOp_t op, input logic [31:0] wd);
        case (modelSize(op))
            1:       return (wd & 32'hFF) * 32'h0101_0101;
            2:       return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    // One load/store; lat = cycles from issue to ready, flushAt = cycle index of a flush pulse
    // (1..lat inside the wait, lat+1 on the completion cycle, -1 for none).
    task automatic runTxn(input MemOp_t op, input logic [31:0] addr, input logic [31:0] wd,
                          input RegWriteReq_t rw, input int lat, input logic [31:0] rd, input int flushAt);
        int stalls = 0;
        bit ld = modelIsLoad(op);
        bit dropped = (flushAt >= 1);
        logic [31:0] expData = ld ? modelLoad(op, addr, rd) : rw.wdata;
        @(posedge clk); #1;
        applyStimulus(1'b1, op, addr, wd, rw, 1'b0, lat == 0, (lat == 0) ? rd : $urandom);
        if (modelMisaligned(op, addr)) begin
            @(negedge clk);
            checkOutput("err_req", dbus_req, 0);
            checkOutput("err_load", addr_err_load, ld);
            checkOutput("err_store", addr_err_store, !ld);
            checkOutput("err_badvaddr", badvaddr, addr);
            checkOutput("err_we", mem_reg_wr.we, 0);
            checkOutput("err_stall", stall_req, 0);
        end else begin
            for (int c = 0; c <= lat; c++) begin
                if (c > 0) begin
                    @(posedge clk); #1;
                    dbus_ready = (c == lat);
                    dbus_rdata = (c == lat) ? rd : $urandom;
                    flush      = (c == flushAt);
                    mem_addr   = $urandom;
                    mem_wdata  = $urandom;
                end
                @(negedge clk);
                checkOutput("bus_req", dbus_req, 1);
                checkOutput("bus_we", dbus_we, !ld);
                checkOutput("bus_addr", dbus_addr, addr & 32'hFFFF_FFFC);
                checkOutput("bus_err", addr_err_load | addr_err_store, 0);
                if (!ld) begin
                    checkOutput("bus_be", dbus_be, modelBe(op, addr));
                    checkOutput("bus_wdata", dbus_wdata, modelStoreData(op, wd));
                end
                if (stall_req) stalls++;
            end
            if (lat > 0) begin
                @(posedge clk); #1;
                dbus_ready = 1'b0;
                flush      = (flushAt == lat + 1);
                @(negedge clk);
                checkOutput("done_stall", stall_req, 0);
                checkOutput("done_req", dbus_req, 0);
            end
            checkOutput("res_we", mem_reg_wr.we, rw.we && !dropped);
            checkOutput("res_waddr", mem_reg_wr.waddr, rw.waddr);
            checkOutput("res_wdata", mem_reg_wr.wdata, expData);
            checkOutput("stall_cycles", stalls, (lat == 0) ? 0 : lat + 1);
        end
        @(posedge clk); #1;
        rw = '{we: 1'($urandom), waddr: 5'($urandom), wdata: $urandom};
        applyStimulus(1'b0, op, $urandom, $urandom, rw, 1'b0, 1'b0, $urandom);
        @(negedge clk);
        checkOutput("idle_req", dbus_req, 0);
        checkOutput("idle_stall", stall_req, 0);
        checkOutput("idle_pass", {mem_reg_wr.we, mem_reg_wr.waddr}, {rw.we, rw.waddr});
        checkOutput("idle_pass_data", mem_reg_wr.wdata, rw.wdata);
    endtask

    function automatic RegWriteReq_t randRw();
        RegWriteReq_t r;
        r.we    = 1'($urandom);
        r.waddr = 5'($urandom);
        r.wdata = $urandom;
        return r;
    endfunction

    initial begin
        #300000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RegWriteReq_t rw;
        rst_n = 1'b0;
        rw = '{we: 1'b1, waddr: 5'd7, wdata: 32'h1234_5678};
        applyStimulus(1'b1, LW, 32'h100, 32'h0, rw, 1'b0, 1'b1, 32'hDEAD_BEEF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req", dbus_req, 0);
        checkOutput("rst_stall", stall_req, 0);
        checkOutput("rst_wr_ctl", {mem_reg_wr.we, mem_reg_wr.waddr}, 0);
        checkOutput("rst_wr_data", mem_reg_wr.wdata, 0);
        checkOutput("rst_err", addr_err_load | addr_err_store, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_req = 1'b0;
        dbus_ready = 1'b0;

        rw = '{we: 1'b1, waddr: 5'd3, wdata: 32'h0};
        runTxn(LB, 32'h1003, 32'h0, rw, 0, 32'h80FF_FF00, -1);
        runTxn(LHU, 32'h2002, 32'h0, rw, 3, 32'hBEEF_1234, -1);
        runTxn(SB, 32'h3001, 32'h0000_00A5, '0, 0, 32'h0, -1);
        runTxn(LW, 32'h4002, 32'h0, rw, 0, 32'h0, -1);
        runTxn(LW, 32'h5000, 32'h0, rw, 2, 32'hCAFE_F00D, 1);
        runTxn(LH, 32'h6002, 32'h0, rw, 1, 32'h8001_0000, 2);
        runTxn(SH, 32'h6006, 32'h0000_BEEF, '0, 2, 32'h0, -1);
        runTxn(SW, 32'h6009, 32'h1, '0, 0, 32'h0, -1);

        // Flush while idle blocks both the access and any address error.
        @(posedge clk); #1;
        applyStimulus(1'b1, LW, 32'h7000, 32'h0, rw, 1'b1, 1'b1, 32'h1);
        @(negedge clk);
        checkOutput("flush_idle_req", dbus_req, 0);
        checkOutput("flush_idle_we", mem_reg_wr.we, 0);
        @(posedge clk); #1;
        mem_addr = 32'h7003;
        @(negedge clk);
        checkOutput("flush_idle_err", addr_err_load | addr_err_store, 0);
        checkOutput("flush_idle_stall", stall_req, 0);

        // Reset in the middle of a wait abandons the access.
        @(posedge clk); #1;
        applyStimulus(1'b1, LW, 32'h7100, 32'h0, rw, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("rb_issue_stall", stall_req, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        mem_op = SH;
        mem_addr = 32'h7101;
        @(negedge clk);
        checkOutput("rb_rst_req", dbus_req, 0);
        checkOutput("rb_rst_stall", stall_req, 0);
        checkOutput("rb_rst_wr", {mem_reg_wr.we, mem_reg_wr.waddr}, 0);
        checkOutput("rb_rst_err", addr_err_load | addr_err_store, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_req = 1'b0;
        dbus_ready = 1'b1;
        dbus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checkOutput("rb_after_req", dbus_req, 0);
        checkOutput("rb_after_stall", stall_req, 0);
        checkOutput("rb_after_pass", mem_reg_wr.wdata, rw.wdata);
        @(posedge clk); #1;
        dbus_ready = 1'b0;
        @(negedge clk);
        checkOutput("rb_next_pass_we", mem_reg_wr.we, rw.we);
        checkOutput("rb_next_pass", mem_reg_wr.wdata, rw.wdata);

        for (int n = 0; n < 120; n++) begin
            MemOp_t op = MemOp_t'($urandom_range(0, 7));
            logic [31:0] addr = $urandom;
            int lat = $urandom_range(0, 4);
            int fa = -1;
            if ($urandom_range(0, 2) != 0) addr = addr & ~(modelSize(op) - 1);
            if (lat > 0 && $urandom_range(0, 3) == 0) fa = $urandom_range(1, lat + 1);
            runTxn(op, addr, $urandom, randRw(), lat, $urandom, fa);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
